// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame deframer, E0/F0 prefix folding.
// Optional macro PS2_PAUSE_SWALLOW_EN silently drops the 8-byte Pause/Break sequence.
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_ext,
    input  logic       ps2data_ext,
    output logic       kb_interrupt,
    output logic [7:0] scancode,
    output logic       released,
    output logic       extended,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic                  clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
    logic                  fclk_q, fclk_d;
    logic                  fall;
    state_e                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic [CntW-1:0]       to_cnt_q, to_cnt_d;
    logic                  rel_pend_q, rel_pend_d, ext_pend_q, ext_pend_d;
    logic                  kb_q, kb_d, err_q, err_d, busy_q, busy_d;
    logic [7:0]            code_q, code_d;
    logic                  rel_q, rel_d, ext_q, ext_d;
`ifdef PS2_PAUSE_SWALLOW_EN
    logic [2:0]            swallow_q, swallow_d;
`endif

    // Filtered level only moves once the whole window agrees.
    always_comb begin
        filt_sr_d = {filt_sr_q[FILTER_LEN-2:0], clk_sync_q};
        fclk_d    = fclk_q;
        if (filt_sr_q == '0) begin
            fclk_d = 1'b0;
        end else if (filt_sr_q == '1) begin
            fclk_d = 1'b1;
        end
        fall = fclk_q & ~fclk_d;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = to_cnt_q;
        rel_pend_d = rel_pend_q;
        ext_pend_d = ext_pend_q;
        kb_d       = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        code_d     = code_q;
        rel_d      = rel_q;
        ext_d      = ext_q;
`ifdef PS2_PAUSE_SWALLOW_EN
        swallow_d  = swallow_q;
`endif
        if (state_q == StIdle) begin
            to_cnt_d = '0;
            if (fall && !dat_sync_q) begin
                state_d   = StData;
                bit_cnt_d = 3'd0;
                busy_d    = 1'b1;
            end
        end else if (fall) begin
            to_cnt_d = '0;
            unique case (state_q)
                StData: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = dat_sync_q;
                    state_d = StStop;
                end
                default: begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    if (dat_sync_q && (^{shift_q, par_q})) begin
`ifdef PS2_PAUSE_SWALLOW_EN
                        if (swallow_q != 3'd0) begin
                            swallow_d = swallow_q - 3'd1;
                        end else if (shift_q == 8'hE1) begin
                            swallow_d = 3'd7;
                        end else
`endif
                        if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_pend_d = 1'b1;
                        end else begin
                            code_d     = shift_q;
                            rel_d      = rel_pend_q;
                            ext_d      = ext_pend_q;
                            kb_d       = 1'b1;
                            rel_pend_d = 1'b0;
                            ext_pend_d = 1'b0;
                        end
                    end else begin
                        err_d      = 1'b1;
                        rel_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
`ifdef PS2_PAUSE_SWALLOW_EN
                        swallow_d  = 3'd0;
`endif
                    end
                end
            endcase
        end else if (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = StIdle;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            rel_pend_d = 1'b0;
            ext_pend_d = 1'b0;
`ifdef PS2_PAUSE_SWALLOW_EN
            swallow_d  = 3'd0;
`endif
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            filt_sr_q  <= '1;
            fclk_q     <= 1'b1;
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            rel_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            kb_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            code_q     <= 8'h00;
            rel_q      <= 1'b0;
            ext_q      <= 1'b0;
`ifdef PS2_PAUSE_SWALLOW_EN
            swallow_q  <= 3'd0;
`endif
        end else begin
            clk_meta_q <= ps2clk_ext;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2data_ext;
            dat_sync_q <= dat_meta_q;
            filt_sr_q  <= filt_sr_d;
            fclk_q     <= fclk_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            rel_pend_q <= rel_pend_d;
            ext_pend_q <= ext_pend_d;
            kb_q       <= kb_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            code_q     <= code_d;
            rel_q      <= rel_d;
            ext_q      <= ext_d;
`ifdef PS2_PAUSE_SWALLOW_EN
            swallow_q  <= swallow_d;
`endif
        end
    end

    assign kb_interrupt = kb_q;
    assign frame_error  = err_q;
    assign busy         = busy_q;
    assign scancode     = code_q;
    assign released     = rel_q;
    assign extended     = ext_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: frames are modelled into an event scoreboard,
// a monitor pops and compares each kb_interrupt event.
module tb_ps2_scancode_rx;

    localparam int unsigned TIMEOUT = 16000;

    typedef struct {
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2clk_ext, ps2data_ext;
    logic       kb_interrupt, released, extended, frame_error, busy;
    logic [7:0] scancode;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    int  exp_err = 0, err_seen = 0;
    bit  m_rel = 0, m_ext = 0;
    int  m_swal = 0;
    logic prev_kb = 1'b0, prev_err = 1'b0;

    ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2clk_ext  (ps2clk_ext),
        .ps2data_ext (ps2data_ext),
        .kb_interrupt(kb_interrupt),
        .scancode    (scancode),
        .released    (released),
        .extended    (extended),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Reference behaviour of the prefix/decode layer for one received byte.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        ev_t e;
        if (!ok) begin
            m_rel = 0; m_ext = 0; m_swal = 0; exp_err++;
            return;
        end
`ifdef PS2_PAUSE_SWALLOW_EN
        if (m_swal > 0) begin m_swal--; return; end
        if (b == 8'hE1) begin m_swal = 7; return; end
`endif
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_rel = 1;
        else begin
            e.code = b; e.rel = m_rel; e.ext = m_ext;
            exp_q.push_back(e);
            m_rel = 0; m_ext = 0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits,
                             input bit glitch);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            ps2data_ext = fr[i];
            cyc(10);
            if (glitch && i == 4) begin
                ps2clk_ext = 1'b0; cyc(3); ps2clk_ext = 1'b1;
            end
            cyc(10);
            ps2clk_ext = 1'b0;
            cyc(40);
            ps2clk_ext = 1'b1;
            cyc(20);
        end
        ps2data_ext = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit glitch = 0);
        model_byte(b, !bad_par);
        send_bits(b, bad_par, 11, glitch);
    endtask

    task automatic settle(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin cyc(1); n++; end
        cyc(5);
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_errs"}, err_seen, exp_err);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (kb_interrupt) begin
                ev_t e;
                chk("kb_width", prev_kb, 1'b0);
                chk("kb_err_excl", frame_error, 1'b0);
                chk("event_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ev_code", scancode, e.code);
                    chk("ev_rel", released, e.rel);
                    chk("ev_ext", extended, e.ext);
                end
            end
            if (frame_error) begin
                err_seen++;
                chk("err_width", prev_err, 1'b0);
            end
        end
        prev_kb  = kb_interrupt;
        prev_err = frame_error;
    end

    initial begin
        rst = 1'b1; ps2clk_ext = 1'b1; ps2data_ext = 1'b1;
        cyc(5);
        rst = 1'b0;
        cyc(2);
        chk("rst_kb", kb_interrupt, 1'b0);
        chk("rst_err", frame_error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_code", scancode, 8'h00);
        chk("rst_rel", released, 1'b0);
        chk("rst_ext", extended, 1'b0);

        send_frame(8'h1C); settle("plain");
        chk("plain_code", scancode, 8'h1C);

        send_frame(8'hF0); send_frame(8'h1C); settle("break");
        send_frame(8'h1B); settle("make_after_break");
        chk("make_rel", released, 1'b0);

        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75); settle("ext_break");
        send_frame(8'h75); settle("ext_clear");
        send_frame(8'hF0); cyc(500); send_frame(8'hE0); send_frame(8'h6B); settle("rev_order");

        send_frame(8'hE0); send_frame(8'h1C, 1'b1); settle("parity_err");
        chk("held_code", scancode, 8'h6B);
        chk("held_rel", released, 1'b1);
        send_frame(8'hF0); send_frame(8'h1C); settle("after_err");
        chk("after_err_ext", extended, 1'b0);

        ps2clk_ext = 1'b0; cyc(3); ps2clk_ext = 1'b1;
        cyc(100); settle("glitch_idle");
        send_frame(8'h2A, 1'b0, 1'b1); settle("glitch_mid");

        send_bits(8'h55, 1'b0, 6, 1'b0);
        chk("mid_busy", busy, 1'b1);
        model_byte(8'h00, 1'b0);
        cyc(TIMEOUT + 20); settle("timeout");
        send_frame(8'h29); settle("post_timeout");

        send_frame(8'hE1); send_frame(8'h14); send_frame(8'h77); send_frame(8'hE1);
        send_frame(8'hF0); send_frame(8'h14); send_frame(8'hF0); send_frame(8'h77);
        send_frame(8'h1C); settle("pause");

        send_frame(8'hE0);
        send_bits(8'h33, 1'b0, 5, 1'b0);
        rst = 1'b1; cyc(3); rst = 1'b0;
        m_rel = 0; m_ext = 0; m_swal = 0;
        cyc(300); settle("mid_reset");
        chk("mid_reset_code", scancode, 8'h00);
        send_frame(8'h1C); settle("post_reset");
        chk("post_reset_ext", extended, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
